i2c_write_engine: RTL

Bit-level I2C master that executes one 3-byte write (slave address, sub-address, data) per request, on the system clock. It sits directly downstream of the audio/video configuration sequencer: it consumes the sequencer's 24-bit word and GO level, drives the codec's SCLK/SDAT pins, and returns END plus an aggregated acknowledge status.

---
 rtl/i2c_write_engine.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/i2c_write_engine.sv
// Bit-level I2C master: one 3-byte write (slave addr, sub-addr, data)
// per GO request, aggregated ACK status returned alongside END.
module i2c_write_engine #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    STOP,
    DONE
  } state_t;

  state_t        state, stateNxt;
  logic [DW-1:0] div;
  logic [1:0]    q, qNxt;
  logic [4:0]    slot, slotNxt;
  logic [23:0]   sr, srNxt;
  logic          ack, ackNxt;
  logic          tick;
  logic          ackSlot;
  logic          active;
  logic          sdaLow;
  logic          sdaIn;

  assign tick    = (div == DW'(DIV - 1));
  assign ackSlot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  assign active  = (state == START) || (state == SHIFT) || (state == STOP);
  assign sdaIn   = I2C_SDAT;

  assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;
  assign oEND     = (state == DONE);
  assign oBUSY    = active;
  assign oACK     = ack;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= IDLE;
      div   <= '0;
      q     <= '0;
      slot  <= '0;
      sr    <= '0;
      ack   <= 1'b0;
    end else begin
      state <= stateNxt;
      q     <= qNxt;
      slot  <= slotNxt;
      sr    <= srNxt;
      ack   <= ackNxt;
      if (!active || tick)
        div <= '0;
      else
        div <= div + DW'(1);
    end
  end

  always_comb begin
    stateNxt = state;
    qNxt     = q;
    slotNxt  = slot;
    srNxt    = sr;
    ackNxt   = ack;
    unique case (state)
      IDLE: begin
        if (iGO) begin
          srNxt    = iDATA;
          ackNxt   = 1'b0;
          qNxt     = 2'd0;
          slotNxt  = 5'd0;
          stateNxt = START;
        end
      end
      START: begin
        if (tick) begin
          qNxt = q + 2'd1;
          if (q == 2'd3)
            stateNxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          qNxt = q + 2'd1;
          if (q == 2'd2 && ackSlot)
            ackNxt = ack | sdaIn;
          if (q == 2'd3) begin
            if (!ackSlot)
              srNxt = {sr[22:0], 1'b0};
            if (slot == 5'd26) begin
              slotNxt  = 5'd0;
              stateNxt = STOP;
            end else begin
              slotNxt = slot + 5'd1;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          qNxt = q + 2'd1;
          if (q == 2'd3)
            stateNxt = DONE;
        end
      end
      DONE: begin
        if (!iGO)
          stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Pins decode from registered state only, so they move on clock edges.
  always_comb begin
    I2C_SCLK = 1'b1;
    sdaLow   = 1'b0;
    unique case (1'b1)
      (state == START): begin
        I2C_SCLK = (q < 2'd2);
        sdaLow   = (q != 2'd0);
      end
      (state == SHIFT): begin
        I2C_SCLK = (q == 2'd1) || (q == 2'd2);
        sdaLow   = !ackSlot && !sr[23];
      end
      (state == STOP): begin
        I2C_SCLK = (q != 2'd0);
        sdaLow   = (q < 2'd2);
      end
      default: ;
    endcase
  end

endmodule
